// File: rtl/tdc_pulse_gen.sv
// Loopback stimulus generator for the TDC: emits a start pulse and a light_pulse
// edge delayed by a programmed coarse cycle count plus a fine phase tap.
module tdc_pulse_gen #(
    parameter int unsigned START_W = 20,
    parameter int unsigned STOP_W  = 20,
    parameter int unsigned TOF_W   = 13,
    parameter int unsigned PH_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PH_W-1:0]   phase,
    input  logic [TOF_W-1:0]  cfg_tof,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              start,
    output logic              light_pulse,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CRS_W  = TOF_W - 5;
    localparam int unsigned FINE_W = 5;
    localparam int unsigned SC_W   = $clog2(START_W + 1);
    localparam int unsigned SS_W   = $clog2(STOP_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STOP,
        TAIL,
        DONE
    } state_t;

    state_t              state;
    logic [CRS_W-1:0]    coarse_q;
    logic [FINE_W-1:0]   fine_q;
    logic [CRS_W-1:0]    cnt;
    logic [SC_W-1:0]     start_cnt;
    logic [SS_W-1:0]     scnt;
    logic                stop_win;
    logic                hold_q;

    assign cfg_ready   = rst & (state == IDLE);
    assign light_pulse = stop_win & (phase[fine_q] | hold_q);

    // Sequencer; the start timer runs alongside the FSM so start width never depends on coarse
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            coarse_q  <= '0;
            fine_q    <= '0;
            cnt       <= '0;
            start_cnt <= '0;
            scnt      <= '0;
            stop_win  <= 1'b0;
            hold_q    <= 1'b0;
            start     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;

            if (start) begin
                if (start_cnt == SC_W'(START_W - 1)) begin
                    start <= 1'b0;
                end else begin
                    start_cnt <= start_cnt + SC_W'(1);
                end
            end

            if (stop_win && phase[fine_q]) begin
                hold_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        coarse_q  <= cfg_tof[TOF_W-1:FINE_W];
                        fine_q    <= cfg_tof[FINE_W-1:0];
                        cnt       <= '0;
                        scnt      <= '0;
                        start_cnt <= '0;
                        start     <= 1'b1;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // Compare before increment so coarse=255 never wraps
                    if (cnt == coarse_q) begin
                        stop_win <= 1'b1;
                        state    <= STOP;
                    end else begin
                        cnt <= cnt + CRS_W'(1);
                    end
                end
                STOP: begin
                    if (scnt == SS_W'(STOP_W - 1)) begin
                        stop_win <= 1'b0;
                        hold_q   <= 1'b0;
                        err      <= ~(hold_q | phase[fine_q]);
                        state    <= TAIL;
                    end else begin
                        scnt <= scnt + SS_W'(1);
                    end
                end
                TAIL: begin
                    if (!start) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_pulse_gen.sv
// Randomized scoreboard bench for tdc_pulse_gen: a timeline model predicts each
// sequence at handshake; a monitor checks the observed sequence at done.
module tb_tdc_pulse_gen;

    localparam int START_W = 20;
    localparam int STOP_W  = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] phase = 32'hFFFF_FFFF;
    logic [12:0] cfg_tof = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready, start, light_pulse, busy, done, err;

    tdc_pulse_gen #(
        .START_W(START_W),
        .STOP_W (STOP_W),
        .TOF_W  (13),
        .PH_W   (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .phase      (phase),
        .cfg_tof    (cfg_tof),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .start      (start),
        .light_pulse(light_pulse),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int start_first;
        int start_cnt;
        int lp_first;
        int lp_cnt;
        int busy_cnt;
        int done_cyc;
        int err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   mode = 0;

    // cyc == e during the cycle following posedge number e
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] phase_fn(input int m, input int t);
        logic [63:0] dbl;
        logic [31:0] h;
        case (m)
            0: return 32'hFFFF_FFFF;
            1: return 32'h0000_0000;
            2: begin
                dbl = {32'h0000_FFFF, 32'h0000_FFFF} >> (t % 32);
                return dbl[31:0];
            end
            3: begin
                h = 32'(t) * 32'h9E37_79B1;
                return h ^ (h >> 15);
            end
            default: return ((t % 37) == 5) ? 32'hFFFF_FFFF : 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        phase = phase_fn(mode, cyc);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timeline derived from the request: start for START_W cycles, window of STOP_W
    // cycles opening coarse+1 after start, light held from first tap hit to window end
    function automatic exp_t model(input int k, input logic [12:0] tof, input int m);
        exp_t        e;
        int          c, f, open, close, tail;
        logic [31:0] ph;
        c = int'(tof[12:5]);
        f = int'(tof[4:0]);
        e.start_first = k;
        e.start_cnt   = START_W;
        open  = k + c + 1;
        close = open + STOP_W - 1;
        e.lp_first = -1;
        for (int t = open; t <= close; t++) begin
            ph = phase_fn(m, t);
            if (ph[f] && e.lp_first < 0) e.lp_first = t;
        end
        e.lp_cnt   = (e.lp_first < 0) ? 0 : close - e.lp_first + 1;
        e.err      = (e.lp_first < 0) ? 1 : 0;
        tail       = close + 1;
        e.done_cyc = ((tail > k + START_W) ? tail : k + START_W) + 1;
        e.busy_cnt = e.done_cyc - k + 1;
        return e;
    endfunction

    // Monitor: accumulates what the DUT shows and checks it when done appears
    int s_first, s_cnt, l_first, l_cnt, b_cnt;

    task automatic clear_acc();
        s_first = -1;
        s_cnt   = 0;
        l_first = -1;
        l_cnt   = 0;
        b_cnt   = 0;
    endtask

    initial begin
        exp_t e;
        clear_acc();
        forever begin
            @(negedge clk);
            if (!rst) begin
                clear_acc();
            end else begin
                if (start) begin
                    if (s_first < 0) s_first = cyc;
                    s_cnt++;
                end
                if (light_pulse) begin
                    if (l_first < 0) l_first = cyc;
                    l_cnt++;
                end
                if (busy) b_cnt++;
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("start_first", s_first, e.start_first);
                        chk("start_cnt", s_cnt, e.start_cnt);
                        chk("lp_first", l_first, e.lp_first);
                        chk("lp_cnt", l_cnt, e.lp_cnt);
                        chk("busy_cnt", b_cnt, e.busy_cnt);
                        chk("done_cyc", cyc, e.done_cyc);
                        chk("err", int'(err), e.err);
                    end
                    clear_acc();
                end
            end
        end
    end

    // Drive a request every cycle until accepted; returns the handshake edge and prediction
    task automatic issue(input logic [12:0] tof, output int k, output exp_t e);
        int guard = 0;
        int rdy_busy = 0;
        k = -1;
        while (k < 0) begin
            @(negedge clk);
            #2;
            cfg_valid = 1'b1;
            cfg_tof   = tof;
            if (cfg_ready && busy) rdy_busy++;
            if (cfg_ready && rst) begin
                k = cyc + 1;
                e = model(k, tof, mode);
                sb.push_back(e);
            end else if (++guard > 2000) begin
                chk("issue_timeout", guard, 0);
                k = 0;
            end
        end
        chk("ready_while_busy", rdy_busy, 0);
    endtask

    // Wait for IDLE while wiggling cfg inputs, which must be ignored
    task automatic wait_idle();
        int guard = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!busy && cfg_ready) begin
                cfg_valid = 1'b0;
                break;
            end
            cfg_valid = 1'($urandom);
            cfg_tof   = 13'($urandom);
            if (++guard > 2000) begin
                chk("idle_timeout", guard, 0);
                cfg_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_one(input int m, input logic [12:0] tof);
        int   k;
        exp_t e;
        mode = m;
        issue(tof, k, e);
        wait_idle();
    endtask

    initial begin
        int   ka, kb, guard;
        exp_t ea, eb;

        repeat (3) @(negedge clk);
        #2;
        chk("rst_start", int'(start), 0);
        chk("rst_lp", int'(light_pulse), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_ready", int'(cfg_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("ready_after_rst", int'(cfg_ready), 1);

        run_one(0, 13'd64);
        run_one(2, 13'd90);
        run_one(1, 13'd300);
        chk("err_sticky", int'(err), 1);
        run_one(0, 13'd0);
        run_one(0, 13'd8191);

        // Back-to-back: valid stays high, second request changes cfg_tof while busy
        mode = 0;
        issue(13'd37, ka, ea);
        issue(13'd129, kb, eb);
        chk("b2b_accept_edge", kb, ea.done_cyc + 2);
        wait_idle();

        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_one(int'($urandom_range(0, 4)), 13'($urandom));
        end

        // Reset while light_pulse is high
        mode = 0;
        issue(13'd96, ka, ea);
        guard = 0;
        do begin
            @(negedge clk);
            #2;
            cfg_valid = 1'b0;
            guard++;
        end while (!light_pulse && guard < 200);
        chk("lp_seen_before_rst", int'(light_pulse), 1);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        #2;
        chk("abort_start", int'(start), 0);
        chk("abort_lp", int'(light_pulse), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_err", int'(err), 0);
        chk("abort_ready", int'(cfg_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("ready_after_abort", int'(cfg_ready), 1);

        run_one(4, 13'd555);
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
